// File: rtl/round_sched.sv
// round_sched: two requesters (A, B) share one rounding datapath through a
// two-stage pipeline. S1 holds the captured request and its tag, S2 holds the
// registered rounded result and flags.
// Build option: define ROUND_SCHED_FIXED_PRIO_EN for fixed-priority arbitration
// (A always beats B). The default build is round-robin with a last_grant bit.

module rounding_module #(
  parameter int IS_DOUBLE = 0,
  parameter int TOTAL_WIDTH = (IS_DOUBLE != 0) ? 106 : 48,
  parameter int HIGH_PART_WIDTH = (IS_DOUBLE != 0) ? 52 : 23,
  parameter int LOW_PART_WIDTH = (IS_DOUBLE != 0) ? 53 : 24
) (
  input  logic [1:0]                 mode,
  input  logic                       sign,
  input  logic [TOTAL_WIDTH-1:0]     value,
  output logic [HIGH_PART_WIDTH-1:0] rounded,
  output logic                       precise,
  output logic                       overflow,
  output logic                       no_round
);
  localparam int HW = HIGH_PART_WIDTH;
  localparam int LW = LOW_PART_WIDTH;

  logic [HW-1:0] high;
  logic [LW-1:0] low;
  logic          guard;
  logic          sticky;
  logic          inc;
  logic          all_ones;
  logic          unused_top;

  // The top bit above the high/low split does not take part in rounding.
  assign unused_top = value[TOTAL_WIDTH-1];

  // Split, pick the per-mode increment, saturate when the high part wraps.
  always_comb begin
    high     = value[HW+LW-1:LW];
    low      = value[LW-1:0];
    guard    = low[LW-1];
    sticky   = |low[LW-2:0];
    all_ones = &high;
    inc      = 1'b0;
    case (mode)
      2'b00:   inc = 1'b0;
      2'b01:   inc = ~sign & (|low);
      2'b10:   inc = sign & (|low);
      default: inc = guard & (sticky | high[0]);
    endcase
    if (inc && all_ones) begin
      rounded = {1'b0, {(HW-1){1'b1}}};
    end else begin
      rounded = high + {{(HW-1){1'b0}}, inc};
    end
    precise  = ~(|low);
    overflow = all_ones & inc;
    no_round = ~inc;
  end
endmodule

module round_sched #(
  parameter int IS_DOUBLE = 0,
  parameter int TOTAL_WIDTH = (IS_DOUBLE != 0) ? 106 : 48,
  parameter int HIGH_PART_WIDTH = (IS_DOUBLE != 0) ? 52 : 23,
  parameter int LOW_PART_WIDTH = (IS_DOUBLE != 0) ? 53 : 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [1:0]                 a_mode,
  input  logic [TOTAL_WIDTH-1:0]     a_value,
  input  logic                       a_sign,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [1:0]                 b_mode,
  input  logic [TOTAL_WIDTH-1:0]     b_value,
  input  logic                       b_sign,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [HIGH_PART_WIDTH-1:0] out_rounded,
  output logic                       out_tag,
  output logic                       out_precise,
  output logic                       out_overflow,
  output logic                       out_no_round
);
  logic                       s1_valid_q, s1_valid_d;
  logic [1:0]                 s1_mode_q, s1_mode_d;
  logic                       s1_sign_q, s1_sign_d;
  logic [TOTAL_WIDTH-1:0]     s1_value_q, s1_value_d;
  logic                       s1_tag_q, s1_tag_d;
  logic                       s2_valid_q, s2_valid_d;
  logic [HIGH_PART_WIDTH-1:0] s2_rounded_q, s2_rounded_d;
  logic                       s2_tag_q, s2_tag_d;
  logic                       s2_precise_q, s2_precise_d;
  logic                       s2_overflow_q, s2_overflow_d;
  logic                       s2_no_round_q, s2_no_round_d;
`ifndef ROUND_SCHED_FIXED_PRIO_EN
  logic                       last_grant_q, last_grant_d;
`endif

  logic                       s2_load;
  logic                       s1_open;
  logic                       grant_a;
  logic                       grant_b;
  logic [HIGH_PART_WIDTH-1:0] rnd_value;
  logic                       rnd_precise;
  logic                       rnd_overflow;
  logic                       rnd_no_round;

  rounding_module #(
    .IS_DOUBLE      (IS_DOUBLE),
    .TOTAL_WIDTH    (TOTAL_WIDTH),
    .HIGH_PART_WIDTH(HIGH_PART_WIDTH),
    .LOW_PART_WIDTH (LOW_PART_WIDTH)
  ) u_round (
    .mode    (s1_mode_q),
    .sign    (s1_sign_q),
    .value   (s1_value_q),
    .rounded (rnd_value),
    .precise (rnd_precise),
    .overflow(rnd_overflow),
    .no_round(rnd_no_round)
  );

  // Arbitration and pipeline advance; ready is held low while in reset.
  always_comb begin
    s2_load = s1_valid_q & (~s2_valid_q | out_ready);
    s1_open = ~s1_valid_q | s2_load;
`ifdef ROUND_SCHED_FIXED_PRIO_EN
    grant_a = a_valid;
    grant_b = b_valid & ~a_valid;
`else
    grant_a = a_valid & (~b_valid | last_grant_q);
    grant_b = b_valid & (~a_valid | ~last_grant_q);
`endif
    a_ready = s1_open & grant_a & ~rst;
    b_ready = s1_open & grant_b & ~rst;
  end

  // Next-state for both stages and the grant history.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_mode_d     = s1_mode_q;
    s1_sign_d     = s1_sign_q;
    s1_value_d    = s1_value_q;
    s1_tag_d      = s1_tag_q;
    s2_valid_d    = s2_valid_q;
    s2_rounded_d  = s2_rounded_q;
    s2_tag_d      = s2_tag_q;
    s2_precise_d  = s2_precise_q;
    s2_overflow_d = s2_overflow_q;
    s2_no_round_d = s2_no_round_q;
`ifndef ROUND_SCHED_FIXED_PRIO_EN
    last_grant_d  = last_grant_q;
`endif
    if (s2_load) begin
      s2_valid_d    = 1'b1;
      s2_rounded_d  = rnd_value;
      s2_tag_d      = s1_tag_q;
      s2_precise_d  = rnd_precise;
      s2_overflow_d = rnd_overflow;
      s2_no_round_d = rnd_no_round;
      s1_valid_d    = 1'b0;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
    if (a_ready) begin
      s1_valid_d = 1'b1;
      s1_mode_d  = a_mode;
      s1_sign_d  = a_sign;
      s1_value_d = a_value;
      s1_tag_d   = 1'b0;
`ifndef ROUND_SCHED_FIXED_PRIO_EN
      last_grant_d = 1'b0;
`endif
    end else if (b_ready) begin
      s1_valid_d = 1'b1;
      s1_mode_d  = b_mode;
      s1_sign_d  = b_sign;
      s1_value_d = b_value;
      s1_tag_d   = 1'b1;
`ifndef ROUND_SCHED_FIXED_PRIO_EN
      last_grant_d = 1'b1;
`endif
    end
  end

  // Pipeline registers; reset empties both stages and lets A win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_mode_q     <= 2'b00;
      s1_sign_q     <= 1'b0;
      s1_value_q    <= '0;
      s1_tag_q      <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_rounded_q  <= '0;
      s2_tag_q      <= 1'b0;
      s2_precise_q  <= 1'b0;
      s2_overflow_q <= 1'b0;
      s2_no_round_q <= 1'b0;
`ifndef ROUND_SCHED_FIXED_PRIO_EN
      last_grant_q  <= 1'b1;
`endif
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_mode_q     <= s1_mode_d;
      s1_sign_q     <= s1_sign_d;
      s1_value_q    <= s1_value_d;
      s1_tag_q      <= s1_tag_d;
      s2_valid_q    <= s2_valid_d;
      s2_rounded_q  <= s2_rounded_d;
      s2_tag_q      <= s2_tag_d;
      s2_precise_q  <= s2_precise_d;
      s2_overflow_q <= s2_overflow_d;
      s2_no_round_q <= s2_no_round_d;
`ifndef ROUND_SCHED_FIXED_PRIO_EN
      last_grant_q  <= last_grant_d;
`endif
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_rounded  = s2_rounded_q;
  assign out_tag      = s2_tag_q;
  assign out_precise  = s2_precise_q;
  assign out_overflow = s2_overflow_q;
  assign out_no_round = s2_no_round_q;
endmodule

// File: tb/tb_round_sched.sv
// Bench for round_sched (single precision): directed vector table, multi-cycle
// sequences for arbitration/backpressure/reset, then randomized traffic against
// an arithmetic reference model with a result queue.
module tb_round_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [1:0]  a_mode, b_mode;
  logic [47:0] a_value, b_value;
  logic        a_sign, b_sign;
  logic        out_valid, out_ready;
  logic [22:0] out_rounded;
  logic        out_tag, out_precise, out_overflow, out_no_round;

  always #5 clk = ~clk;

  round_sched dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_mode(a_mode), .a_value(a_value), .a_sign(a_sign),
    .b_valid(b_valid), .b_ready(b_ready), .b_mode(b_mode), .b_value(b_value), .b_sign(b_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_rounded(out_rounded), .out_tag(out_tag),
    .out_precise(out_precise), .out_overflow(out_overflow), .out_no_round(out_no_round)
  );

  typedef struct packed {
    logic [1:0]  mode;
    logic        sign;
    logic [47:0] value;
    logic [22:0] r;
    logic        p, o, n;
  } vec_t;

  typedef struct packed {
    logic [22:0] r;
    logic        p, o, n, tag;
  } exp_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input exp_t e);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_rounded"}, 64'(out_rounded), 64'(e.r));
    chk({name, "_tag"}, 64'(out_tag), 64'(e.tag));
    chk({name, "_flags"}, 64'({out_precise, out_overflow, out_no_round}), 64'({e.p, e.o, e.n}));
  endtask

  // Reference rounding from plain integer arithmetic on the 48-bit magnitude.
  function automatic exp_t model_round(input logic [1:0] mode, input logic sign,
                                       input logic [47:0] v, input logic tag);
    longint unsigned vv, hi, lo, sum;
    bit inc;
    exp_t e;
    vv  = 64'(v);
    hi  = (vv >> 24) % 64'd8388608;
    lo  = vv % 64'd16777216;
    case (mode)
      2'd0:    inc = 1'b0;
      2'd1:    inc = (lo != 0) && !sign;
      2'd2:    inc = (lo != 0) && sign;
      default: inc = (lo > 64'd8388608) || (lo == 64'd8388608 && (hi % 2) == 1);
    endcase
    sum   = hi + (inc ? 64'd1 : 64'd0);
    e.tag = tag;
    e.p   = (lo == 0);
    e.n   = !inc;
    if (sum >= 64'd8388608) begin
      e.r = 23'h3FFFFF;
      e.o = 1'b1;
    end else begin
      e.r = 23'(sum);
      e.o = 1'b0;
    end
    return e;
  endfunction

  task automatic idle();
    a_valid = 0; b_valid = 0; a_mode = 0; b_mode = 0; a_sign = 0; b_sign = 0;
    a_value = '0; b_value = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[13];
  exp_t q[$];
  exp_t ex;
  bit   m_s1, m_s2, m_lg, take, move, acc, acc_tag, exp_a, exp_b, can;
  logic [63:0] r64;
  logic [47:0] rv;
  logic        tie_tag[4];

  initial begin
    vecs[0]  = {2'b00, 1'b0, 48'h7FFFFF800000, 23'h7FFFFF, 1'b0, 1'b0, 1'b1};
    vecs[1]  = {2'b01, 1'b0, 48'h000001C00000, 23'h000002, 1'b0, 1'b0, 1'b0};
    vecs[2]  = {2'b10, 1'b1, 48'h000001C00000, 23'h000002, 1'b0, 1'b0, 1'b0};
    vecs[3]  = {2'b01, 1'b0, 48'hFFFFFFFFFFFF, 23'h3FFFFF, 1'b0, 1'b1, 1'b0};
    vecs[4]  = {2'b11, 1'b0, 48'h000001600000, 23'h000001, 1'b0, 1'b0, 1'b1};
    vecs[5]  = {2'b11, 1'b0, 48'h000002800000, 23'h000002, 1'b0, 1'b0, 1'b1};
    vecs[6]  = {2'b11, 1'b1, 48'h000003800000, 23'h000004, 1'b0, 1'b0, 1'b0};
    vecs[7]  = {2'b11, 1'b0, 48'h000001800001, 23'h000002, 1'b0, 1'b0, 1'b0};
    vecs[8]  = {2'b01, 1'b1, 48'h000005000001, 23'h000005, 1'b0, 1'b0, 1'b1};
    vecs[9]  = {2'b10, 1'b0, 48'h000005000000, 23'h000005, 1'b1, 1'b0, 1'b1};
    vecs[10] = {2'b10, 1'b1, 48'h7FFFFF000001, 23'h3FFFFF, 1'b0, 1'b1, 1'b0};
    vecs[11] = {2'b00, 1'b1, 48'h800004000000, 23'h000004, 1'b1, 1'b0, 1'b1};
    vecs[12] = {2'b11, 1'b0, 48'h7FFFFFFFFFFF, 23'h3FFFFF, 1'b0, 1'b1, 1'b0};

    idle();
    out_ready = 1'b1;
    rst = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'({a_ready, b_ready}), 64'd0);
    chk("rst_outputs", 64'({out_rounded, out_tag, out_precise, out_overflow, out_no_round}), 64'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;

    // Tie straight after reset: A first, B on the next cycle.
    a_valid = 1; a_mode = 2'b01; a_sign = 0; a_value = 48'h000001C00000;
    b_valid = 1; b_mode = 2'b10; b_sign = 1; b_value = 48'h000001C00000;
    #1;
    chk("tie_first_ready", 64'({a_ready, b_ready}), 64'b10);
    @(negedge clk);
    a_valid = 0;
    #1;
    chk("tie_second_ready", 64'({a_ready, b_ready}), 64'b01);
    chk("tie_latency", 64'(out_valid), 64'd0);
    @(negedge clk);
    b_valid = 0;
    chk_out("tie_out_a", '{r: 23'h2, p: 1'b0, o: 1'b0, n: 1'b0, tag: 1'b0});
    @(negedge clk);
    chk_out("tie_out_b", '{r: 23'h2, p: 1'b0, o: 1'b0, n: 1'b0, tag: 1'b1});
    @(negedge clk);
    chk("tie_drained", 64'(out_valid), 64'd0);

    // Single-request vectors: accept, one cycle in S1, then visible on the output.
    for (int i = 0; i < 13; i++) begin
      a_valid = 1; a_mode = vecs[i].mode; a_sign = vecs[i].sign; a_value = vecs[i].value;
      #1;
      chk($sformatf("vec%0d_ready", i), 64'(a_ready), 64'd1);
      @(negedge clk);
      a_valid = 0;
      chk($sformatf("vec%0d_latency", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), '{r: vecs[i].r, p: vecs[i].p, o: vecs[i].o, n: vecs[i].n, tag: 1'b0});
    end
    @(negedge clk);
    chk("vec_drained", 64'(out_valid), 64'd0);

    // Backpressure: two results buffered, ready drops, output holds.
    out_ready = 0;
    a_valid = 1; a_mode = 2'b11; a_sign = 0; a_value = 48'h000001600000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d_a_ready", i), 64'(a_ready), (i < 2) ? 64'd1 : 64'd0);
      if (i >= 2) chk_out($sformatf("bp%0d_hold", i), '{r: 23'h1, p: 1'b0, o: 1'b0, n: 1'b1, tag: 1'b0});
      else chk($sformatf("bp%0d_valid", i), 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    a_valid = 0;
    out_ready = 1;
    #1;
    chk_out("bp_rel0", '{r: 23'h1, p: 1'b0, o: 1'b0, n: 1'b1, tag: 1'b0});
    @(negedge clk);
    chk_out("bp_rel1", '{r: 23'h1, p: 1'b0, o: 1'b0, n: 1'b1, tag: 1'b0});
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Reset with both stages full: everything discarded asynchronously.
    out_ready = 0;
    a_valid = 1; a_mode = 2'b00; a_sign = 0; a_value = 48'h000009000000;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_a_ready", 64'(a_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(a_ready), 64'd0);
    chk("async_rst_out", 64'({out_rounded, out_tag}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1;
    a_value = 48'h000005000000;
    #1;
    chk("post_rst_ready", 64'(a_ready), 64'd1);
    @(negedge clk);
    a_valid = 0;
    chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk_out("post_rst_out", '{r: 23'h5, p: 1'b1, o: 1'b0, n: 1'b1, tag: 1'b0});
    @(negedge clk);
    chk("post_rst_drained", 64'(out_valid), 64'd0);

    // Repeated ties from a clean reset.
    do_reset();
    a_valid = 1; b_valid = 1; a_value = 48'h000001000000; b_value = 48'h000002000000;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i < 4) begin
`ifdef ROUND_SCHED_FIXED_PRIO_EN
        tie_tag[i] = 1'b0;
`else
        tie_tag[i] = 1'(i % 2);
`endif
        chk($sformatf("rtie%0d_ready", i), 64'({a_ready, b_ready}), tie_tag[i] ? 64'b01 : 64'b10);
      end
      if (i >= 2) begin
        chk($sformatf("rtie%0d_tag", i), 64'(out_tag), 64'(tie_tag[i-2]));
        chk($sformatf("rtie%0d_val", i), 64'(out_rounded), tie_tag[i-2] ? 64'd2 : 64'd1);
      end
      @(negedge clk);
      if (i == 3) begin a_valid = 0; b_valid = 0; end
    end

    // Randomized traffic against the model.
    do_reset();
    m_s1 = 0; m_s2 = 0; m_lg = 1;
    q.delete();
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        r64 = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       rv = r64[47:0];
          1:       rv = {r64[47:24], 24'h800000};
          2:       rv = {1'b0, 23'h7FFFFF, r64[23:0]};
          default: rv = {r64[47:24], 20'h0, r64[3:0]};
        endcase
        if (k == 0) begin
          a_valid = ($urandom_range(0, 2) != 0); a_mode = 2'($urandom); a_sign = 1'($urandom); a_value = rv;
        end else begin
          b_valid = ($urandom_range(0, 2) != 0); b_mode = 2'($urandom); b_sign = 1'($urandom); b_value = rv;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      can = !m_s1 || !m_s2 || out_ready;
`ifdef ROUND_SCHED_FIXED_PRIO_EN
      exp_a = can && a_valid;
      exp_b = can && b_valid && !a_valid;
`else
      exp_a = can && a_valid && (!b_valid || m_lg);
      exp_b = can && b_valid && (!a_valid || !m_lg);
`endif
      chk("rnd_ready", 64'({a_ready, b_ready}), 64'({exp_a, exp_b}));
      chk("rnd_out_valid", 64'(out_valid), 64'(m_s2));
      if (m_s2 && q.size() > 0) chk_out("rnd_out", q[0]);
      acc = exp_a || exp_b;
      acc_tag = exp_b;
      @(posedge clk);
      take = m_s2 && out_ready;
      if (take && q.size() > 0) void'(q.pop_front());
      move = m_s1 && (!m_s2 || out_ready);
      m_s2 = move || (m_s2 && !out_ready);
      m_s1 = acc || (m_s1 && !move);
      if (acc) begin
        ex = acc_tag ? model_round(b_mode, b_sign, b_value, 1'b1)
                     : model_round(a_mode, a_sign, a_value, 1'b0);
        q.push_back(ex);
        m_lg = acc_tag;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
